// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - bank of NREG accumulators with ALU flags and a DEPTH-entry shadow stack
// One op per enabled cycle on acc[sel]; PUSH/POP move values between acc[sel] and the stack.
module acc_bank #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [2:0]               i_op,
    input  logic [$clog2(NREG)-1:0]  i_sel,
    input  logic [WIDTH-1:0]         i_in,
    output logic [WIDTH-1:0]         o_out,
    output logic                     o_z_out,
    output logic                     o_n_out,
    output logic                     o_c_out,
    output logic                     o_v_out,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_err
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int SIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    logic [WIDTH-1:0] r_acc   [NREG];
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic             r_z, r_n, r_c, r_v, r_err;

    logic [WIDTH-1:0] w_cur, w_top, w_res, w_diff;
    logic [WIDTH:0]   w_sum;
    logic             w_full, w_empty;
    logic             w_wr, w_push, w_pop, w_rej;
    logic             w_z_nxt, w_n_nxt, w_c_nxt, w_v_nxt;

    assign w_cur   = r_acc[i_sel];
    assign w_full  = (r_sp == SPW'(DEPTH));
    assign w_empty = (r_sp == '0);
    assign w_top   = r_stack[SIW'(r_sp - SPW'(1))];
    assign w_sum   = {1'b0, w_cur} + {1'b0, i_in};
    assign w_diff  = w_cur - i_in;

    always_comb begin
        w_wr    = 1'b0;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_rej   = 1'b0;
        w_res   = w_cur;
        w_z_nxt = r_z;
        w_n_nxt = r_n;
        w_c_nxt = r_c;
        w_v_nxt = r_v;
        if (i_en) begin
            case (i_op)
                OP_LOAD: begin
                    w_wr = 1'b1; w_res = i_in; w_c_nxt = 1'b0; w_v_nxt = 1'b0;
                end
                OP_ADD: begin
                    w_wr    = 1'b1;
                    w_res   = w_sum[MSB:0];
                    w_c_nxt = w_sum[WIDTH];
                    w_v_nxt = (w_cur[MSB] == i_in[MSB]) && (w_sum[MSB] != w_cur[MSB]);
                end
                OP_SUB: begin
                    // C is the unsigned borrow, not the inverted carry of a two's-complement adder
                    w_wr    = 1'b1;
                    w_res   = w_diff;
                    w_c_nxt = (i_in > w_cur);
                    w_v_nxt = (w_cur[MSB] != i_in[MSB]) && (w_diff[MSB] != w_cur[MSB]);
                end
                OP_AND: begin
                    w_wr = 1'b1; w_res = w_cur & i_in; w_c_nxt = 1'b0; w_v_nxt = 1'b0;
                end
                OP_OR: begin
                    w_wr = 1'b1; w_res = w_cur | i_in; w_c_nxt = 1'b0; w_v_nxt = 1'b0;
                end
                OP_PUSH: begin
                    if (!w_full) w_push = 1'b1;
                    else         w_rej  = 1'b1;
                end
                OP_POP: begin
                    if (!w_empty) begin
                        w_pop = 1'b1; w_wr = 1'b1; w_res = w_top;
                        w_c_nxt = 1'b0; w_v_nxt = 1'b0;
                    end else begin
                        w_rej = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (w_wr) begin
            w_z_nxt = (w_res == '0);
            w_n_nxt = w_res[MSB];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) r_acc[i] <= '0;
            r_sp  <= '0;
            r_z   <= 1'b1;
            r_n   <= 1'b0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_wr) r_acc[i_sel] <= w_res;
            if (w_push)     r_sp <= r_sp + SPW'(1);
            else if (w_pop) r_sp <= r_sp - SPW'(1);
            r_z   <= w_z_nxt;
            r_n   <= w_n_nxt;
            r_c   <= w_c_nxt;
            r_v   <= w_v_nxt;
            r_err <= w_rej;
        end
    end

    // Stack contents are don't-care after reset, so the storage carries no reset
    always_ff @(posedge i_clk) begin
        if (w_push) r_stack[SIW'(r_sp)] <= w_cur;
    end

    assign o_out   = w_cur;
    assign o_z_out = r_z;
    assign o_n_out = r_n;
    assign o_c_out = r_c;
    assign o_v_out = r_v;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_err   = r_err;
endmodule
